// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_unit
//  Description : Iterative unsigned multiply/divide execute unit. It reads
//                operands and rd from the ID/EX register and stalls the front
//                of the pipe while it iterates. It then presents a registered
//                XLEN-bit result plus rd for one DONE cycle.
//                Operations: MUL, MULHU, DIVU, REMU.
//  Ports       : clk        - pipeline clock, rising edge
//                reset      - asynchronous active-low reset
//                valid_in   - ID/EX holds a mul/div instruction
//                op         - 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//                operand_a  - first source operand (rs1 data)
//                operand_b  - second source operand (rs2 data)
//                rd_in      - destination register
//                flush      - synchronous kill of the operation in flight
//                stall      - hold PC, IF/ID and ID/EX this cycle
//                done       - result/rd_out valid this cycle
//                result     - registered result
//                rd_out     - registered destination of result
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    state_t            state;
    state_t            state_nxt;

    // sel_high: MULHU selects the product high half, REMU the remainder.
    logic              sel_high;
    // opnd: multiplicand (MUL) or divisor (DIV).
    logic [XLEN-1:0]   opnd;
    // lo: multiplier shifting out / product low half shifting in (MUL),
    //     dividend shifting out / quotient shifting in (DIV).
    logic [XLEN-1:0]   lo;
    // hi: product high half (MUL) or partial remainder (DIV).
    logic [XLEN-1:0]   hi;
    logic [CNT_W-1:0]  count;
    logic [4:0]        rd_q;

    logic              accept;
    logic              b_zero;
    logic              last_iter;

    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   mul_hi_nxt;
    logic [XLEN-1:0]   mul_lo_nxt;

    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;
    logic [XLEN-1:0]   div_hi_nxt;
    logic [XLEN-1:0]   div_lo_nxt;

    always_comb begin
        accept    = (state == S_IDLE) && valid_in && !flush;
        b_zero    = (operand_b == '0);
        last_iter = (count == LAST_ITER);

        // Shift-add step: add the multiplicand into the high half when the
        // current multiplier bit is set, then shift the 2*XLEN product right.
        // The carry out of the add becomes the new MSB of the high half.
        mul_sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        mul_hi_nxt = mul_sum[XLEN:1];
        mul_lo_nxt = {mul_sum[0], lo[XLEN-1:1]};

        // Restoring step: the trial difference is one bit wider than XLEN so
        // its MSB is the sign. A negative trial restores the shifted value.
        div_shift  = {hi, lo[XLEN-1]};
        div_trial  = div_shift - {1'b0, opnd};
        div_hi_nxt = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
        div_lo_nxt = {lo[XLEN-2:0], ~div_trial[XLEN]};
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!op[1])      state_nxt = S_MUL;
                    else if (b_zero) state_nxt = S_DONE;
                    else             state_nxt = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (flush)          state_nxt = S_IDLE;
                else if (last_iter) state_nxt = S_DONE;
            end
            // ID/EX still holds the finished instruction during DONE, so
            // valid_in is not looked at here.
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        stall = accept || (state == S_MUL) || (state == S_DIV);
        done  = (state == S_DONE) && !flush;
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_high <= 1'b0;
            opnd     <= '0;
            lo       <= '0;
            hi       <= '0;
            count    <= '0;
            rd_q     <= '0;
            result   <= '0;
            rd_out   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sel_high <= op[0];
                        opnd     <= op[1] ? operand_b : operand_a;
                        lo       <= op[1] ? operand_a : operand_b;
                        hi       <= '0;
                        count    <= '0;
                        rd_q     <= rd_in;
                        // Divide by zero resolves immediately with the
                        // RISC-V defined results.
                        if (op[1] && b_zero) begin
                            result <= op[0] ? operand_a : '1;
                            rd_out <= rd_in;
                        end
                    end
                end
                S_MUL: begin
                    if (!flush) begin
                        hi    <= mul_hi_nxt;
                        lo    <= mul_lo_nxt;
                        count <= last_iter ? '0 : count + CNT_W'(1);
                        if (last_iter) begin
                            result <= sel_high ? mul_hi_nxt : mul_lo_nxt;
                            rd_out <= rd_q;
                        end
                    end
                end
                S_DIV: begin
                    if (!flush) begin
                        hi    <= div_hi_nxt;
                        lo    <= div_lo_nxt;
                        count <= last_iter ? '0 : count + CNT_W'(1);
                        if (last_iter) begin
                            result <= sel_high ? div_hi_nxt : div_lo_nxt;
                            rd_out <= rd_q;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv_unit
//  Description : Scoreboard bench for ex_muldiv_unit. The driver pushes the
//                expected result, rd and completion cycle for each accepted
//                op. A monitor pops and compares on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

    localparam int XLEN = 64;

    logic            clk      = 1'b0;
    logic            reset    = 1'b1;
    logic            valid_in = 1'b0;
    logic            flush    = 1'b0;
    logic [1:0]      op       = 2'd0;
    logic [XLEN-1:0] a        = '0;
    logic [XLEN-1:0] b        = '0;
    logic [4:0]      rd       = '0;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    ex_muldiv_unit #(.XLEN(XLEN), .CNT_W(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .op        (op),
        .operand_a (a),
        .operand_b (b),
        .rd_in     (rd),
        .flush     (flush),
        .stall     (stall),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [XLEN-1:0] res;
        logic [4:0]      rd;
        int              due;
    } exp_t;

    exp_t            sb[$];
    exp_t            mon_e;
    int              checks = 0;
    int              fails  = 0;
    logic [XLEN-1:0] last_res = '0;
    logic [4:0]      last_rd  = '0;

    // Reference model: plain arithmetic on a double-width product.
    function automatic logic [XLEN-1:0] model(input logic [1:0] o,
                                              input logic [XLEN-1:0] x,
                                              input logic [XLEN-1:0] y);
        logic [2*XLEN-1:0] p;
        p = {{XLEN{1'b0}}, x} * {{XLEN{1'b0}}, y};
        case (o)
            2'd0:    return p[XLEN-1:0];
            2'd1:    return p[2*XLEN-1:XLEN];
            2'd2:    return (y == 0) ? {XLEN{1'b1}} : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("result",        result,              mon_e.res);
                check("rd_out",        {59'd0, rd_out},     {59'd0, mon_e.rd});
                check("latency",       64'(cyc),            64'(mon_e.due));
                check("stall_in_done", {63'd0, stall},      64'd0);
            end
        end
    end

    // Issue one op starting just after a rising edge with the DUT idle.
    // Returns just after the edge that closes DONE, with valid_in still set.
    // Back-to-back calls therefore keep valid_in high.
    task automatic do_op(input logic [1:0] o, input logic [XLEN-1:0] x,
                         input logic [XLEN-1:0] y, input logic [4:0] r);
        int  lat;
        bit  seen;
        op = o; a = x; b = y; rd = r; valid_in = 1'b1;
        #1 check("stall_accept", {63'd0, stall}, 64'd1);
        @(posedge clk); #1;
        lat = (o[1] && y == 0) ? 0 : XLEN;
        sb.push_back('{model(o, x, y), r, cyc + lat});
        last_res = model(o, x, y);
        last_rd  = r;
        seen = 0;
        for (int i = 0; i < XLEN + 8 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
            else      check("stall_busy", {63'd0, stall}, 64'd1);
        end
        if (!seen) begin
            checks++;
            fails++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", XLEN + 8);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]      ro;
        logic [XLEN-1:0] ra, rb;

        // Reset state
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", result,              64'd0);
        check("reset_rd",     {59'd0, rd_out},     64'd0);
        check("reset_done",   {63'd0, done},       64'd0);
        check("reset_stall",  {63'd0, stall},      64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed ops, issued back to back
        do_op(2'd0, 64'd3, 64'd5, 5'd7);
        do_op(2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd1);
        do_op(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2);
        do_op(2'd2, 64'd100, 64'd7, 5'd3);
        do_op(2'd3, 64'd100, 64'd7, 5'd4);
        do_op(2'd2, 64'h8000_0000_0000_0000, 64'd1, 5'd5);
        do_op(2'd2, 64'd42, 64'd0, 5'd6);
        do_op(2'd3, 64'd42, 64'd0, 5'd8);
        do_op(2'd0, 64'd6, 64'd7, 5'd9);
        do_op(2'd2, 64'd84, 64'd4, 5'd10);
        valid_in = 1'b0;
        @(posedge clk); #1;

        // Randomized ops
        for (int n = 0; n < 24; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0:       rb = '0;
                1:       rb = 64'($urandom_range(1, 300));
                2:       rb = {32'd0, $urandom};
                default: rb = {$urandom, $urandom};
            endcase
            if ($urandom_range(0, 3) == 0) ra = 64'($urandom_range(0, 1000));
            do_op(ro, ra, rb, 5'($urandom));
        end
        valid_in = 1'b0;
        @(posedge clk); #1;

        // Flush in the 30th cycle of a DIVU: no done, outputs kept
        op = 2'd2; a = 64'd123456789; b = 64'd37; rd = 5'd17; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (29) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_stall",  {63'd0, stall},  64'd0);
        check("flush_done",   {63'd0, done},   64'd0);
        check("flush_result", result,          last_res);
        check("flush_rd",     {59'd0, rd_out}, {59'd0, last_rd});
        repeat (XLEN + 5) @(posedge clk);
        #1 check("flush_result_late", result, last_res);

        // Flush and valid together in IDLE: nothing accepted
        op = 2'd0; a = 64'd9; b = 64'd9; rd = 5'd11; valid_in = 1'b1; flush = 1'b1;
        #1 check("flush_idle_stall", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        valid_in = 1'b0; flush = 1'b0;
        check("flush_idle_not_accepted", {63'd0, stall}, 64'd0);
        repeat (XLEN + 5) @(posedge clk);
        #1;

        // Reset at cycle 40 of a MUL
        op = 2'd0; a = 64'd11; b = 64'd13; rd = 5'd21; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (39) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_result", result,          64'd0);
        check("rst_mid_rd",     {59'd0, rd_out}, 64'd0);
        check("rst_mid_done",   {63'd0, done},   64'd0);
        check("rst_mid_stall",  {63'd0, stall},  64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (XLEN + 5) @(posedge clk);
        #1 check("rst_mid_result_late", result, 64'd0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
